// File: rtl/bcd_field_counter.sv
// Cascadable multi-digit BCD counter for one clock/calendar field: up/down, range-checked load, optional run-time max.
// Count and load_err are registered; carry_out/at_bound are combinational in the en cycle. No backpressure: en is a tick.
module bcd_field_counter #(
  parameter int DIGITS      = 2,
  parameter int MIN         = 0,
  parameter int MAX         = 59,
  parameter int USE_DYN_MAX = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   dyn_max,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  carry_out,
  output logic                  at_bound,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] f_to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] f_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] f_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h3F;
      4'd1:    f_seg = 7'h06;
      4'd2:    f_seg = 7'h5B;
      4'd3:    f_seg = 7'h4F;
      4'd4:    f_seg = 7'h66;
      4'd5:    f_seg = 7'h6D;
      4'd6:    f_seg = 7'h7D;
      4'd7:    f_seg = 7'h07;
      4'd8:    f_seg = 7'h7F;
      4'd9:    f_seg = 7'h6F;
      default: f_seg = 7'h00;
    endcase
  endfunction

  localparam logic [W-1:0] MIN_BCD = f_to_bcd(MIN);
  localparam logic [W-1:0] MAX_BCD = f_to_bcd(MAX);

  logic [W-1:0] r_count;
  logic         r_load_err;
  logic [W-1:0] w_emax;
  logic         w_at_max;
  logic         w_at_min;
  logic         w_nib_ok;
  logic         w_load_ok;

  // Valid BCD orders the same as unsigned binary, so plain vector compares suffice.
  assign w_emax   = (USE_DYN_MAX != 0) ? dyn_max : MAX_BCD;
  assign w_at_max = (r_count >= w_emax);
  assign w_at_min = (r_count <= MIN_BCD);

  always_comb begin
    w_nib_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) w_nib_ok = 1'b0;
    end
  end

  assign w_load_ok = w_nib_ok && (load_val >= MIN_BCD) && (load_val <= w_emax);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= MIN_BCD;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= load & ~w_load_ok;
      if (load) begin
        if (w_load_ok) r_count <= load_val;
      end else if (en) begin
        if (up_dn) r_count <= w_at_max ? MIN_BCD : f_inc(r_count);
        else       r_count <= w_at_min ? w_emax  : f_dec(r_count);
      end
    end
  end

  always_comb begin
    seg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = f_seg(r_count[4*i +: 4]);
    end
  end

  assign at_bound  = up_dn ? w_at_max : w_at_min;
  // Gated by reset_n so a held-in-reset stage never ticks its successor.
  assign carry_out = en & ~load & reset_n & at_bound;
  assign count_bcd = r_count;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Directed bench for bcd_field_counter: seconds/minutes chain, month down-counter, dynamic-max day counter.
module tb_bcd_field_counter;

  logic clk;
  logic reset_n;

  logic       sec_en, sec_up, sec_load;
  logic [7:0] sec_lv;
  logic [7:0] sec_cnt;
  logic [13:0] sec_seg;
  logic       sec_co, sec_ab, sec_le;

  logic [7:0] min_cnt;
  logic [13:0] min_seg;
  logic       min_co, min_ab, min_le;

  logic       mon_en, mon_up, mon_load;
  logic [7:0] mon_lv;
  logic [7:0] mon_cnt;
  logic [13:0] mon_seg;
  logic       mon_co, mon_ab, mon_le;

  logic       day_en, day_up, day_load;
  logic [7:0] day_lv, day_dmax;
  logic [7:0] day_cnt;
  logic [13:0] day_seg;
  logic       day_co, day_ab, day_le;

  int n_chk;
  int n_fail;

  bcd_field_counter #(.DIGITS(2), .MIN(0), .MAX(59), .USE_DYN_MAX(0)) u_sec (
    .clk(clk), .reset_n(reset_n), .en(sec_en), .up_dn(sec_up), .load(sec_load),
    .load_val(sec_lv), .dyn_max(8'h00), .count_bcd(sec_cnt), .seg(sec_seg),
    .carry_out(sec_co), .at_bound(sec_ab), .load_err(sec_le)
  );

  bcd_field_counter #(.DIGITS(2), .MIN(0), .MAX(59), .USE_DYN_MAX(0)) u_min (
    .clk(clk), .reset_n(reset_n), .en(sec_co), .up_dn(sec_up), .load(1'b0),
    .load_val(8'h00), .dyn_max(8'h00), .count_bcd(min_cnt), .seg(min_seg),
    .carry_out(min_co), .at_bound(min_ab), .load_err(min_le)
  );

  bcd_field_counter #(.DIGITS(2), .MIN(1), .MAX(12), .USE_DYN_MAX(0)) u_mon (
    .clk(clk), .reset_n(reset_n), .en(mon_en), .up_dn(mon_up), .load(mon_load),
    .load_val(mon_lv), .dyn_max(8'h00), .count_bcd(mon_cnt), .seg(mon_seg),
    .carry_out(mon_co), .at_bound(mon_ab), .load_err(mon_le)
  );

  bcd_field_counter #(.DIGITS(2), .MIN(1), .MAX(31), .USE_DYN_MAX(1)) u_day (
    .clk(clk), .reset_n(reset_n), .en(day_en), .up_dn(day_up), .load(day_load),
    .load_val(day_lv), .dyn_max(day_dmax), .count_bcd(day_cnt), .seg(day_seg),
    .carry_out(day_co), .at_bound(day_ab), .load_err(day_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] b2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg7(input int d);
    logic [6:0] t [10];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  function automatic logic [13:0] sseg(input int v);
    return {seg7(v / 10), seg7(v % 10)};
  endfunction

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    sec_en = 0; sec_up = 1; sec_load = 0; sec_lv = 8'h00;
    mon_en = 0; mon_up = 1; mon_load = 0; mon_lv = 8'h00;
    day_en = 0; day_up = 1; day_load = 0; day_lv = 8'h00; day_dmax = 8'h31;

    // Reset state
    #12;
    chk_val("rst_sec_cnt", sec_cnt, 8'h00);
    chk_val("rst_sec_seg", sec_seg, {7'h3F, 7'h3F});
    chk_val("rst_sec_le", sec_le, 1'b0);
    chk_val("rst_mon_cnt", mon_cnt, 8'h01);
    chk_val("rst_mon_seg", mon_seg, {7'h3F, 7'h06});
    chk_val("rst_day_cnt", day_cnt, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Up count 00..59 and wrap
    sec_en = 1;
    for (int k = 0; k < 60; k++) begin
      #2;
      chk_val("up_cnt", sec_cnt, b2(k));
      chk_val("up_co", sec_co, k == 59);
      chk_val("up_ab", sec_ab, k == 59);
      chk_val("up_seg", sec_seg, sseg(k));
      step();
    end
    chk_val("up_wrap", sec_cnt, 8'h00);
    chk_val("up_min_tick", min_cnt, 8'h01);
    sec_en = 0;

    // Load checks
    sec_load = 1; sec_lv = 8'h1A;
    step();
    chk_val("ld_nib_hold", sec_cnt, 8'h00);
    chk_val("ld_nib_err", sec_le, 1'b1);
    sec_load = 0;
    step();
    chk_val("ld_err_1cyc", sec_le, 1'b0);
    sec_load = 1; sec_lv = 8'h60;
    step();
    chk_val("ld_rng_hold", sec_cnt, 8'h00);
    chk_val("ld_rng_err", sec_le, 1'b1);
    sec_lv = 8'h45;
    step();
    chk_val("ld_45", sec_cnt, 8'h45);
    chk_val("ld_45_le", sec_le, 1'b0);
    sec_lv = 8'h59;
    step();
    chk_val("ld_59", sec_cnt, 8'h59);
    sec_lv = 8'h23; sec_en = 1;
    #2;
    chk_val("ld_en_co", sec_co, 1'b0);
    chk_val("ld_en_ab", sec_ab, 1'b1);
    step();
    chk_val("ld_en_cnt", sec_cnt, 8'h23);
    sec_load = 0; sec_en = 0;

    // Month down-count borrow from MIN
    mon_up = 0; mon_en = 1;
    #2;
    chk_val("dn_co", mon_co, 1'b1);
    chk_val("dn_ab", mon_ab, 1'b1);
    step();
    chk_val("dn_wrap", mon_cnt, 8'h12);
    #2;
    chk_val("dn_co_12", mon_co, 1'b0);
    step();
    chk_val("dn_11", mon_cnt, 8'h11);
    mon_en = 0;

    // Dynamic maximum shrinking below the count
    day_load = 1; day_lv = 8'h30;
    step();
    chk_val("dyn_ld30", day_cnt, 8'h30);
    day_load = 0;
    #2;
    chk_val("dyn_ab31", day_ab, 1'b0);
    day_dmax = 8'h28;
    #1;
    chk_val("dyn_ab28", day_ab, 1'b1);
    step();
    chk_val("dyn_hold", day_cnt, 8'h30);
    day_load = 1; day_lv = 8'h29;
    step();
    chk_val("dyn_ld_hold", day_cnt, 8'h30);
    chk_val("dyn_ld_err", day_le, 1'b1);
    day_load = 0; day_en = 1;
    #2;
    chk_val("dyn_co", day_co, 1'b1);
    step();
    chk_val("dyn_wrap", day_cnt, 8'h01);
    day_en = 0;

    // Asynchronous reset mid-count
    sec_load = 1; sec_lv = 8'h37;
    step();
    chk_val("ar_ld37", sec_cnt, 8'h37);
    sec_load = 0; sec_en = 1; sec_up = 1;
    #3;
    reset_n = 1'b0;
    #1;
    chk_val("ar_cnt", sec_cnt, 8'h00);
    chk_val("ar_seg", sec_seg, {7'h3F, 7'h3F});
    chk_val("ar_co", sec_co, 1'b0);
    step();
    chk_val("ar_cnt_held", sec_cnt, 8'h00);
    chk_val("ar_co_held", sec_co, 1'b0);
    sec_en = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk_val("ar_rel_cnt", sec_cnt, 8'h00);
    chk_val("ar_rel_min", min_cnt, 8'h00);

    // Seconds -> minutes chain over one hour
    sec_en = 1;
    for (int k = 0; k < 3600; k++) begin
      #2;
      chk_val("ch_min_co", min_co, k == 3599);
      if (k % 600 == 0) chk_val("ch_min_cnt", min_cnt, b2(k / 60));
      if (k == 3599) begin
        chk_val("ch_sec_co", sec_co, 1'b1);
        chk_val("ch_sec_59", sec_cnt, 8'h59);
        chk_val("ch_min_59", min_cnt, 8'h59);
      end
      step();
    end
    chk_val("ch_sec_end", sec_cnt, 8'h00);
    chk_val("ch_min_end", min_cnt, 8'h00);
    sec_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
